mem_arbiter: RTL and testbench



---
 rtl/mem_arbiter_pkg.sv | 19 +
 rtl/arb_select.sv | 55 +++++
 rtl/mem_arbiter.sv | 105 ++++++++++
 tb/tb_mem_arbiter.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arbiter_pkg.sv
// rtl/mem_arbiter_pkg.sv - shared encodings and constants for the I/D memory arbiter
package mem_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_RESP  = 2'd2
    } state_t;

    typedef enum logic {
        OWN_I = 1'b0,
        OWN_D = 1'b1
    } owner_t;

    // ramRData is valid this many cycles after ramRStrb; the ISSUE -> RESP
    // sequence is built around a value of 1.
    localparam int RAM_RD_LATENCY = 1;

endpackage

// File: rtl/arb_select.sv
// rtl/arb_select.sv - winner selection between fetch (I) and data (D) requesters
// Ports:
//   clk, reset : clock, asynchronous active-low reset
//   i_req      : I request eligible for arbitration this cycle
//   d_req      : D request eligible for arbitration this cycle
//   d_block    : raw D request line (fixed priority lets it hold I off)
//   grant      : a transaction is being granted this cycle (pointer update)
//   win_valid  : some requester wins
//   win_d      : 1 = D wins, 0 = I wins
// Build option MEM_ARB_ROUND_ROBIN_EN: round-robin between simultaneous
// contenders; when undefined, D always beats I and no pointer exists.
module arb_select (
    input  logic clk,
    input  logic reset,
    input  logic i_req,
    input  logic d_req,
    input  logic d_block,
    input  logic grant,
    output logic win_valid,
    output logic win_d
);

`ifdef MEM_ARB_ROUND_ROBIN_EN
    // 1: D is preferred on the next tie, 0: I is preferred.
    logic ptr_d;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ptr_d <= 1'b1;
        end else if (grant) begin
            ptr_d <= ~win_d;
        end
    end

    always_comb begin
        win_valid = i_req | d_req;
        win_d     = d_req;
        if (i_req && d_req) begin
            win_d = ptr_d;
        end
    end

    logic unused_block;
    assign unused_block = d_block;
`else
    // A pending D request starves I even while that D request is being
    // completed and is itself ineligible; I only gets in once dReq drops.
    assign win_valid = d_req | (i_req & ~d_block);
    assign win_d     = d_req;

    logic unused_ports;
    assign unused_ports = ^{clk, reset, grant};
`endif

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - two-requester (fetch/data) arbiter onto one single-port RAM
// Ports:
//   clk, reset                        : clock, asynchronous active-low reset
//   iReq, iAddr / iRData, iAck        : instruction-fetch request and response
//   dReq, dAddr, dWData, dWMask       : data load/store request (mask 0 = load)
//   dRData, dAck                      : data response
//   ramAddr, ramRStrb, ramWData,
//   ramWMask / ramRData               : shared RAM port
// Build option MEM_ARB_ROUND_ROBIN_EN selects round-robin instead of D-first
// priority (see arb_select).
module mem_arbiter
    import mem_arbiter_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        iReq,
    input  logic [31:0] iAddr,
    output logic [31:0] iRData,
    output logic        iAck,
    input  logic        dReq,
    input  logic [31:0] dAddr,
    input  logic [31:0] dWData,
    input  logic [3:0]  dWMask,
    output logic [31:0] dRData,
    output logic        dAck,
    output logic [31:0] ramAddr,
    output logic        ramRStrb,
    output logic [31:0] ramWData,
    output logic [3:0]  ramWMask,
    input  logic [31:0] ramRData
);

    state_t      state;
    state_t      state_nx;
    owner_t      owner;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [3:0]  mask_q;

    logic elig_i;
    logic elig_d;
    logic win_valid;
    logic win_d;
    logic grant;
    logic is_read;

    // Nothing is eligible in ISSUE (one transaction outstanding); in RESP the
    // owner is being completed, so only the other side may be picked.
    assign elig_i = iReq && ((state == ST_IDLE) || ((state == ST_RESP) && (owner != OWN_I)));
    assign elig_d = dReq && ((state == ST_IDLE) || ((state == ST_RESP) && (owner != OWN_D)));
    assign grant  = win_valid;

    arb_select u_arb_select (
        .clk       (clk),
        .reset     (reset),
        .i_req     (elig_i),
        .d_req     (elig_d),
        .d_block   (dReq),
        .grant     (grant),
        .win_valid (win_valid),
        .win_d     (win_d)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= ST_IDLE;
            owner   <= OWN_D;
            addr_q  <= 32'd0;
            wdata_q <= 32'd0;
            mask_q  <= 4'd0;
        end else begin
            state <= state_nx;
            if (grant) begin
                owner   <= win_d ? OWN_D : OWN_I;
                addr_q  <= win_d ? dAddr : iAddr;
                wdata_q <= win_d ? dWData : 32'd0;
                mask_q  <= win_d ? dWMask : 4'd0;
            end
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE:  if (grant) state_nx = ST_ISSUE;
            ST_ISSUE: state_nx = ST_RESP;
            ST_RESP:  state_nx = grant ? ST_ISSUE : ST_IDLE;
            default:  state_nx = ST_IDLE;
        endcase
    end

    // Strobes decode straight from state so an asynchronous reset drops them
    // in the same instant.
    assign is_read  = (mask_q == 4'd0);
    assign ramAddr  = addr_q;
    assign ramWData = wdata_q;
    assign ramRStrb = (state == ST_ISSUE) && is_read;
    assign ramWMask = (state == ST_ISSUE) ? mask_q : 4'd0;

    assign iAck   = (state == ST_RESP) && (owner == OWN_I);
    assign dAck   = (state == ST_RESP) && (owner == OWN_D);
    assign iRData = (iAck && is_read) ? ramRData : 32'd0;
    assign dRData = (dAck && is_read) ? ramRData : 32'd0;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - self-checking bench for mem_arbiter (reference model + directed vectors)
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        iReq = 1'b0;
    logic [31:0] iAddr = 32'd0;
    logic [31:0] iRData;
    logic        iAck;
    logic        dReq = 1'b0;
    logic [31:0] dAddr = 32'd0;
    logic [31:0] dWData = 32'd0;
    logic [3:0]  dWMask = 4'd0;
    logic [31:0] dRData;
    logic        dAck;
    logic [31:0] ramAddr;
    logic        ramRStrb;
    logic [31:0] ramWData;
    logic [3:0]  ramWMask;
    logic [31:0] ramRData;
    logic [31:0] ram_q = 32'd0;

    int checks = 0;
    int passes = 0;

    always #5 clk = ~clk;

    mem_arbiter dut (
        .clk(clk), .reset(reset),
        .iReq(iReq), .iAddr(iAddr), .iRData(iRData), .iAck(iAck),
        .dReq(dReq), .dAddr(dAddr), .dWData(dWData), .dWMask(dWMask),
        .dRData(dRData), .dAck(dAck),
        .ramAddr(ramAddr), .ramRStrb(ramRStrb), .ramWData(ramWData),
        .ramWMask(ramWMask), .ramRData(ramRData)
    );

    // RAM contents are a fixed function of the address; 0x100 holds DEADBEEF.
    function automatic logic [31:0] ram_fn(input logic [31:0] a);
        if (a == 32'h100) return 32'hDEADBEEF;
        return (a * 32'h9E3779B1) ^ 32'h5A5A5A5A;
    endfunction

    always @(posedge clk) if (ramRStrb) ram_q <= ram_fn(ramAddr);
    assign ramRData = ram_q;

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0b expected %0b at %0t", name, act, exp, $time);
    endtask

    // Reference model: phase 0 = free, 1 = RAM access cycle, 2 = answer cycle.
    int          m_phase;
    logic        m_own_d;
    logic        m_ptr_d;
    logic [31:0] m_addr;
    logic [31:0] m_wdata;
    logic [3:0]  m_mask;

    task automatic model_reset();
        m_phase = 0; m_own_d = 1'b1; m_ptr_d = 1'b1;
        m_addr = 32'd0; m_wdata = 32'd0; m_mask = 4'd0;
    endtask

    task automatic model_step();
        logic ai, ad, wv, wd;
        ai = iReq && (m_phase != 1) && !(m_phase == 2 && !m_own_d);
        ad = dReq && (m_phase != 1) && !(m_phase == 2 && m_own_d);
`ifdef MEM_ARB_ROUND_ROBIN_EN
        wv = ai || ad;
        wd = (ai && ad) ? m_ptr_d : ad;
`else
        wv = ad || (ai && !dReq);
        wd = ad;
`endif
        if (m_phase == 1) begin
            m_phase = 2;
        end else if (wv) begin
            m_phase = 1;
            m_own_d = wd;
            m_ptr_d = !wd;
            m_addr  = wd ? dAddr : iAddr;
            m_mask  = wd ? dWMask : 4'd0;
            m_wdata = wd ? dWData : 32'd0;
        end else begin
            m_phase = 0;
        end
    endtask

    always @(posedge clk or negedge reset) begin
        if (!reset) model_reset();
        else model_step();
    end

    always @(negedge clk) begin
        logic ei, ed;
        ei = (m_phase == 2) && !m_own_d;
        ed = (m_phase == 2) && m_own_d;
        chk1("m_iAck", iAck, ei);
        chk1("m_dAck", dAck, ed);
        chk1("m_ramRStrb", ramRStrb, (m_phase == 1) && (m_mask == 4'd0));
        chk32("m_ramWMask", 32'(ramWMask), 32'((m_phase == 1) ? m_mask : 4'd0));
        chk32("m_ramAddr", ramAddr, m_addr);
        if (m_phase == 1 && m_mask != 4'd0) chk32("m_ramWData", ramWData, m_wdata);
        if (ei) chk32("m_iRData", iRData, ram_fn(m_addr));
        if (ed && m_mask == 4'd0) chk32("m_dRData", dRData, ram_fn(m_addr));
        chk1("one_ack_only", iAck && dAck, 1'b0);
        chk1("strobe_excl_mask", ramRStrb && (ramWMask != 4'd0), 1'b0);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [8:0] got_i, got_d, exp_i, exp_d;
    int          w, exp_w;
    logic        i_acked, d_acked;
    int          i_age, d_age, max_i_age, max_d_age;

    initial begin
        model_reset();
        repeat (3) tick();
        chk1("rst_iAck", iAck, 1'b0);
        chk1("rst_dAck", dAck, 1'b0);
        chk1("rst_ramRStrb", ramRStrb, 1'b0);
        chk32("rst_ramWMask", 32'(ramWMask), 32'd0);
        chk32("rst_ramAddr", ramAddr, 32'd0);
        chk32("rst_ramWData", ramWData, 32'd0);
        chk32("rst_iRData", iRData, 32'd0);
        chk32("rst_dRData", dRData, 32'd0);
        @(negedge clk) reset = 1'b1;
        tick();

        // Store: strobe pattern at N+1, ack at N+2.
        dReq = 1'b1; dAddr = 32'h204; dWData = 32'h11223344; dWMask = 4'b1100;
        tick();
        chk32("st_ramWMask", 32'(ramWMask), 32'hC);
        chk1("st_ramRStrb", ramRStrb, 1'b0);
        chk32("st_ramAddr", ramAddr, 32'h204);
        chk32("st_ramWData", ramWData, 32'h11223344);
        chk1("st_no_early_ack", dAck, 1'b0);
        tick();
        chk1("st_dAck", dAck, 1'b1);
        chk1("st_no_iAck", iAck, 1'b0);
        tick();
        dReq = 1'b0; dWMask = 4'd0;
        repeat (2) tick();

        // Fetch: read strobe at N+1, data at N+2.
        iReq = 1'b1; iAddr = 32'h100;
        tick();
        chk1("ld_ramRStrb", ramRStrb, 1'b1);
        chk32("ld_ramAddr", ramAddr, 32'h100);
        chk32("ld_ramWMask", 32'(ramWMask), 32'd0);
        tick();
        chk1("ld_iAck", iAck, 1'b1);
        chk32("ld_iRData", iRData, 32'hDEADBEEF);
        tick();
        iReq = 1'b0;
        repeat (2) tick();

        // Both requesters held continuously.
        iReq = 1'b1; iAddr = 32'h180;
        dReq = 1'b1; dAddr = 32'h280; dWMask = 4'd0;
        got_i = '0; got_d = '0;
        for (int k = 1; k <= 8; k++) begin
            tick();
            got_i[k] = iAck;
            got_d[k] = dAck;
        end
`ifdef MEM_ARB_ROUND_ROBIN_EN
        exp_d = 9'b0_0100_0100; exp_i = 9'b1_0001_0000; exp_w = 3;
`else
        exp_d = 9'b1_0010_0100; exp_i = 9'b0_0000_0000; exp_w = 2;
`endif
        chk32("both_dack_cycles", 32'(got_d), 32'(exp_d));
        chk32("both_iack_cycles", 32'(got_i), 32'(exp_i));
        tick();
        dReq = 1'b0;
        w = 0;
        while (!iAck && w < 20) begin
            tick();
            w++;
        end
        chk32("i_after_d_drop_wait", 32'(w), 32'(exp_w));
        tick();
        iReq = 1'b0;
        repeat (3) tick();

        // Reset during ISSUE of a load.
        dReq = 1'b1; dAddr = 32'h300; dWMask = 4'd0;
        tick();
        chk1("rr_issue_strobe", ramRStrb, 1'b1);
        #1 reset = 1'b0;
        #1;
        chk1("rr_strobe_drop", ramRStrb, 1'b0);
        chk1("rr_no_dack", dAck, 1'b0);
        chk32("rr_addr_clear", ramAddr, 32'd0);
        tick();
        chk1("rr_no_dack_later", dAck, 1'b0);
        @(negedge clk) reset = 1'b1;
        tick();
        chk1("rr_reissue_strobe", ramRStrb, 1'b1);
        chk32("rr_reissue_addr", ramAddr, 32'h300);
        tick();
        chk1("rr_reissue_dack", dAck, 1'b1);
        tick();
        dReq = 1'b0;
        repeat (2) tick();

        // Random requesters obeying the hold-until-ack protocol.
        i_acked = 1'b0; d_acked = 1'b0;
        i_age = 0; d_age = 0; max_i_age = 0; max_d_age = 0;
        for (int c = 0; c < 3000; c++) begin
            tick();
            if (i_acked || !iReq) begin
                iReq = 1'b0;
                if ($urandom_range(0, 9) < 6) begin
                    iReq = 1'b1;
                    iAddr = $urandom & ~32'h3;
                end
                i_acked = 1'b0; i_age = 0;
            end else begin
                i_age++;
            end
            if (d_acked || !dReq) begin
                dReq = 1'b0;
                if ($urandom_range(0, 9) < 6) begin
                    dReq = 1'b1;
                    dAddr = $urandom & ~32'h3;
                    dWData = $urandom;
                    dWMask = ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
                end
                d_acked = 1'b0; d_age = 0;
            end else begin
                d_age++;
            end
            if (i_age > max_i_age) max_i_age = i_age;
            if (d_age > max_d_age) max_d_age = d_age;
            if (iAck) chk32("iAck_maps_to_req", 32'({iReq, i_acked}), 32'h2);
            if (dAck) chk32("dAck_maps_to_req", 32'({dReq, d_acked}), 32'h2);
            i_acked = iAck;
            d_acked = dAck;
        end
        chk1("d_wait_bounded", max_d_age <= 8, 1'b1);
`ifdef MEM_ARB_ROUND_ROBIN_EN
        chk1("i_wait_bounded", max_i_age <= 8, 1'b1);
`else
        chk1("i_wait_bounded", max_i_age <= 200, 1'b1);
`endif
        iReq = 1'b0; dReq = 1'b0;
        repeat (4) tick();

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
